// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared load-size encodings and register constants for the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] LS_BYTE    = 2'b00;
  localparam logic [1:0] LS_HALF    = 2'b01;
  localparam logic [1:0] LS_WORD    = 2'b10;
  localparam logic [1:0] LS_ILLEGAL = 2'b11;

  localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Little-endian lane select and sign/zero extension of load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_ext_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_data[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_ext_data = '0;
    o_misalign = 1'b0;
    case (i_size)
      LS_BYTE: begin
        o_ext_data = i_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                : {{(DATA_W-8){w_byte[7]}}, w_byte};
      end
      LS_HALF: begin
        o_misalign = i_addr_lo[0];
        o_ext_data = i_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                : {{(DATA_W-16){w_half[15]}}, w_half};
      end
      LS_WORD: begin
        o_misalign = (i_addr_lo != 2'b00);
        o_ext_data = i_data;
      end
      default: o_misalign = 1'b1;
    endcase
    // A faulting load never produces meaningful data; keep the bus quiet.
    if (o_misalign) o_ext_data = '0;
  end

endmodule : load_extend

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register, writeback mux, misalign flag and
//               retired-instruction counter driving the register file port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              flush,
  input  logic              halt,
  output logic [REG_AW-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              WrEn,
  output logic              wb_misalign,
  output logic [31:0]       retired_count
);

  logic              w_accept;
  logic [DATA_W-1:0] w_ext_data;
  logic              w_ext_misalign;
  logic              w_fault;
  logic [DATA_W-1:0] w_wb_data;
  logic              r_valid_q;

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .i_data     (in_load_data),
    .i_addr_lo  (in_alu_result[1:0]),
    .i_size     (in_load_size),
    .i_unsigned (in_load_unsigned),
    .o_ext_data (w_ext_data),
    .o_misalign (w_ext_misalign)
  );

  assign in_ready  = ~halt;
  assign w_accept  = in_valid & ~halt & ~flush;
  // Alignment only matters for loads; ALU results pass straight through.
  assign w_fault   = in_memtoreg & w_ext_misalign;
  assign w_wb_data = in_memtoreg ? w_ext_data : in_alu_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_q     <= 1'b0;
      RW            <= '0;
      BusW          <= '0;
      WrEn          <= 1'b0;
      wb_misalign   <= 1'b0;
      retired_count <= '0;
    end else begin
      r_valid_q   <= w_accept;
      WrEn        <= w_accept & in_regwrite & (in_rd != REG_ZERO) & ~w_fault;
      wb_misalign <= w_accept & w_fault;
      if (w_accept) begin
        RW   <= in_rd;
        BusW <= w_wb_data;
      end
      // Counts the instruction during its writeback cycle, so it lands one edge later.
      if (r_valid_q && !wb_misalign) retired_count <= retired_count + 32'd1;
    end
  end

endmodule : mem_wb_stage

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for the MEM/WB writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic        in_memtoreg = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_load_data = '0;
  logic [1:0]  in_load_size = '0;
  logic        in_load_unsigned = 1'b0;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        WrEn;
  logic        wb_misalign;
  logic [31:0] retired_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_rd            (in_rd),
    .in_regwrite      (in_regwrite),
    .in_memtoreg      (in_memtoreg),
    .in_alu_result    (in_alu_result),
    .in_load_data     (in_load_data),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .flush            (flush),
    .halt             (halt),
    .RW               (RW),
    .BusW             (BusW),
    .WrEn             (WrEn),
    .wb_misalign      (wb_misalign),
    .retired_count    (retired_count)
  );

  // Present an instruction and let one edge capture it; sampling at +1.
  task automatic issue(input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] data,
                       input logic [1:0] size, input logic uns);
    in_valid = 1'b1; in_rd = rd; in_regwrite = rw; in_memtoreg = m2r;
    in_alu_result = alu; in_load_data = data; in_load_size = size;
    in_load_unsigned = uns;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (WrEn !== 1'b0 || RW !== 5'd0 || BusW !== 32'd0 || wb_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got WrEn=%b RW=%0d BusW=%h mis=%b, want all 0",
               WrEn, RW, BusW, wb_misalign);
    end
    vectors++;
    if (retired_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %h want 0", retired_count);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || WrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got ready=%b WrEn=%b want 1/0", in_ready, WrEn);
    end
  endtask

  task automatic test_alu_write();
    issue(5'd5, 1'b1, 1'b0, 32'h12345678, 32'h0, 2'b00, 1'b0);
    vectors++;
    if (RW !== 5'd5 || BusW !== 32'h12345678 || WrEn !== 1'b1 || wb_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_write: got RW=%0d BusW=%h WrEn=%b mis=%b want 5/12345678/1/0",
               RW, BusW, WrEn, wb_misalign);
    end
    idle();
    exp_cnt = 32'd1;
    vectors++;
    if (WrEn !== 1'b0 || retired_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL alu_after: got WrEn=%b cnt=%0d want 0/%0d", WrEn, retired_count, exp_cnt);
    end
  endtask

  task automatic test_byte_loads();
    logic [1:0]  addr [3] = '{2'd3, 2'd3, 2'd1};
    logic        uns  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exp  [3] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F};
    for (int i = 0; i < 3; i++) begin
      issue(5'd7, 1'b1, 1'b1, {30'h400, addr[i]}, 32'h80FF7F01, 2'b00, uns[i]);
      vectors++;
      if (BusW !== exp[i] || WrEn !== 1'b1 || RW !== 5'd7) begin
        miscompares++;
        $display("FAIL byte_load[%0d]: got BusW=%h WrEn=%b RW=%0d want %h/1/7",
                 i, BusW, WrEn, RW, exp[i]);
      end
    end
    idle();
    exp_cnt += 32'd3;
    vectors++;
    if (retired_count !== exp_cnt || WrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_count: got cnt=%0d WrEn=%b want %0d/0", retired_count, WrEn, exp_cnt);
    end
  endtask

  task automatic test_half_misalign();
    issue(5'd8, 1'b1, 1'b1, 32'h2002, 32'h8001ABCD, 2'b01, 1'b0);
    vectors++;
    if (BusW !== 32'hFFFF8001 || WrEn !== 1'b1 || wb_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL half_hi: got BusW=%h WrEn=%b mis=%b want FFFF8001/1/0", BusW, WrEn, wb_misalign);
    end
    issue(5'd8, 1'b1, 1'b1, 32'h2000, 32'h8001ABCD, 2'b10, 1'b0);
    vectors++;
    if (BusW !== 32'h8001ABCD || WrEn !== 1'b1) begin
      miscompares++;
      $display("FAIL word_ok: got BusW=%h WrEn=%b want 8001ABCD/1", BusW, WrEn);
    end
    idle();
    exp_cnt += 32'd2;
    vectors++;
    if (retired_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL half_count: got %0d want %0d", retired_count, exp_cnt);
    end
    issue(5'd8, 1'b1, 1'b1, 32'h2001, 32'h8001ABCD, 2'b01, 1'b0);
    vectors++;
    if (WrEn !== 1'b0 || wb_misalign !== 1'b1 || BusW !== 32'd0) begin
      miscompares++;
      $display("FAIL half_misalign: got WrEn=%b mis=%b BusW=%h want 0/1/0", WrEn, wb_misalign, BusW);
    end
    issue(5'd8, 1'b1, 1'b1, 32'h2002, 32'h8001ABCD, 2'b10, 1'b0);
    vectors++;
    if (WrEn !== 1'b0 || wb_misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL word_misalign: got WrEn=%b mis=%b want 0/1", WrEn, wb_misalign);
    end
    issue(5'd8, 1'b1, 1'b1, 32'h2000, 32'h8001ABCD, 2'b11, 1'b0);
    vectors++;
    if (WrEn !== 1'b0 || wb_misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_size: got WrEn=%b mis=%b want 0/1", WrEn, wb_misalign);
    end
    idle();
    vectors++;
    if (retired_count !== exp_cnt || wb_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_count: got cnt=%0d mis=%b want %0d/0", retired_count, wb_misalign, exp_cnt);
    end
  endtask

  task automatic test_rd_zero();
    issue(5'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 2'b11, 1'b0);
    vectors++;
    if (WrEn !== 1'b0 || wb_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_zero: got WrEn=%b mis=%b want 0/0", WrEn, wb_misalign);
    end
    idle();
    exp_cnt += 32'd1;
    vectors++;
    if (retired_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL rd_zero_count: got %0d want %0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_flush_halt();
    flush = 1'b1;
    issue(5'd3, 1'b1, 1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
    vectors++;
    if (WrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL flush: got WrEn=%b want 0", WrEn);
    end
    halt = 1'b1;
    issue(5'd3, 1'b1, 1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
    flush = 1'b0;
    vectors++;
    if (WrEn !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_halt: got WrEn=%b ready=%b want 0/0", WrEn, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      issue(5'd3, 1'b1, 1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
      vectors++;
      if (WrEn !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL halt[%0d]: got WrEn=%b ready=%b want 0/0", i, WrEn, in_ready);
      end
    end
    halt = 1'b0;
    issue(5'd9, 1'b1, 1'b0, 32'h55, 32'h0, 2'b00, 1'b0);
    vectors++;
    if (WrEn !== 1'b1 || RW !== 5'd9 || BusW !== 32'h55) begin
      miscompares++;
      $display("FAIL unhalt: got WrEn=%b RW=%0d BusW=%h want 1/9/55", WrEn, RW, BusW);
    end
    idle();
    exp_cnt += 32'd1;
    vectors++;
    if (retired_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL flush_halt_count: got %0d want %0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    issue(5'd4, 1'b1, 1'b0, 32'hA5A5, 32'h0, 2'b00, 1'b0);
    in_valid = 1'b0;
    vectors++;
    if (WrEn !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got WrEn=%b want 1", WrEn);
    end
    #2 rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    vectors++;
    if (WrEn !== 1'b0 || retired_count !== exp_cnt || RW !== 5'd0) begin
      miscompares++;
      $display("FAIL async_reset: got WrEn=%b cnt=%0d RW=%0d want 0/0/0", WrEn, retired_count, RW);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (WrEn !== 1'b0 || retired_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL post_reset: got WrEn=%b cnt=%0d want 0/0", WrEn, retired_count);
    end
  endtask

  task automatic test_wrap();
    issue(5'd1, 1'b1, 1'b0, 32'h1, 32'h0, 2'b00, 1'b0);
    in_valid = 1'b0;
    force dut.retired_count = 32'hFFFFFFFF;
    #2 release dut.retired_count;
    @(posedge clk); #1;
    vectors++;
    if (retired_count !== 32'd0) begin
      miscompares++;
      $display("FAIL count_wrap: got %h want 00000000", retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_byte_loads();
    test_half_misalign();
    test_rd_zero();
    test_flush_halt();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_wb_stage

`default_nettype wire
